// File: rtl/simple_calculator.sv
// Push-button 8-bit calculator with a multiplexed 4-digit 7-segment display.
// Five debounced buttons edit operand A, operand B and a 2-bit operator;
// the centre button computes a 16-bit result shown as four hex digits.
module simple_calculator #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REFRESH_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnS,
    input  logic       sw,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned OPND_W  = 8;
    localparam int unsigned RES_W   = 16;

    // Bit positions of the buttons inside the conditioned vectors
    localparam int unsigned BTN_D = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_S = 4;

    // Digit codes: 0..15 are hex glyphs, the rest are special characters
    localparam logic [4:0] DIG_A     = 5'h0A;
    localparam logic [4:0] DIG_B     = 5'h0B;
    localparam logic [4:0] DIG_BLANK = 5'h10;
    localparam logic [4:0] DIG_O     = 5'h11;

    typedef enum logic [1:0] {
        FLD_A  = 2'd0,
        FLD_B  = 2'd1,
        FLD_OP = 2'd2
    } field_t;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_prev;
    logic [DB_W-1:0]    db_cnt [NUM_BTN];
    logic               sw_sync1;
    logic               sw_sync2;
    logic [NUM_BTN-1:0] pulse_c;

    assign btn_raw = {btnS, btnR, btnL, btnU, btnD};

    // Two-flop synchronizers for the buttons and the step switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            sw_sync1 <= 1'b0;
            sw_sync2 <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            sw_sync1 <= sw;
            sw_sync2 <= sw_sync1;
        end
    end

    // Debouncers: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= '0;
            level_prev <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            level_prev <= level;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle press pulses on the debounced rising edge
    assign pulse_c = level & ~level_prev;

    // ------------------------------------------------------------------
    // Calculator state
    // ------------------------------------------------------------------
    field_t             field_q, field_d;
    logic [OPND_W-1:0]  a_q, a_d;
    logic [OPND_W-1:0]  b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               show_q, show_d;
    logic [OPND_W-1:0]  step_c;
    logic [RES_W-1:0]   calc_c;

    // State register for the edit/compute controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_q  <= FLD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'd0;
            result_q <= '0;
            show_q   <= 1'b0;
        end else begin
            field_q  <= field_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            show_q   <= show_d;
        end
    end

    // Arithmetic unit selected by the operator code
    always_comb begin
        calc_c = '0;
        case (op_q)
            2'd0:    calc_c = RES_W'(a_q) + RES_W'(b_q);
            2'd1:    calc_c = RES_W'(a_q) - RES_W'(b_q);
            2'd2:    calc_c = RES_W'(a_q) * RES_W'(b_q);
            default: calc_c = RES_W'(a_q & b_q);
        endcase
    end

    // Next-state logic: one prioritized button action per cycle
    always_comb begin
        field_d  = field_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        show_d   = show_q;
        step_c   = sw_sync2 ? OPND_W'(16) : OPND_W'(1);

        if (pulse_c[BTN_S]) begin
            result_d = calc_c;
            show_d   = 1'b1;
        end else if (pulse_c[BTN_R]) begin
            show_d = 1'b0;
            case (field_q)
                FLD_A:   field_d = FLD_B;
                FLD_B:   field_d = FLD_OP;
                default: field_d = FLD_A;
            endcase
        end else if (pulse_c[BTN_L]) begin
            show_d = 1'b0;
            case (field_q)
                FLD_A:   field_d = FLD_OP;
                FLD_B:   field_d = FLD_A;
                default: field_d = FLD_B;
            endcase
        end else if (pulse_c[BTN_U]) begin
            show_d = 1'b0;
            case (field_q)
                FLD_A:   a_d  = a_q + step_c;
                FLD_B:   b_d  = b_q + step_c;
                default: op_d = op_q + 2'd1;
            endcase
        end else if (pulse_c[BTN_D]) begin
            show_d = 1'b0;
            case (field_q)
                FLD_A:   a_d  = a_q - step_c;
                FLD_B:   b_d  = b_q - step_c;
                default: op_d = op_q - 2'd1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display
    // ------------------------------------------------------------------
    logic [RF_W-1:0] rf_cnt;
    logic [1:0]      scan_idx;
    logic [4:0]      digit_c [4];
    logic [4:0]      cur_digit_c;
    logic [6:0]      glyph_c;

    // Scan timer: advance the lit digit every REFRESH_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_cnt   <= '0;
            scan_idx <= 2'd0;
        end else if (rf_cnt == RF_W'(REFRESH_CYCLES - 1)) begin
            rf_cnt   <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            rf_cnt <= rf_cnt + RF_W'(1);
        end
    end

    // Digit contents for the current view (index 0 is the rightmost digit)
    always_comb begin
        digit_c[0] = DIG_BLANK;
        digit_c[1] = DIG_BLANK;
        digit_c[2] = DIG_BLANK;
        digit_c[3] = DIG_BLANK;
        if (show_q) begin
            digit_c[0] = {1'b0, result_q[3:0]};
            digit_c[1] = {1'b0, result_q[7:4]};
            digit_c[2] = {1'b0, result_q[11:8]};
            digit_c[3] = {1'b0, result_q[15:12]};
        end else begin
            case (field_q)
                FLD_A: begin
                    digit_c[3] = DIG_A;
                    digit_c[1] = {1'b0, a_q[7:4]};
                    digit_c[0] = {1'b0, a_q[3:0]};
                end
                FLD_B: begin
                    digit_c[3] = DIG_B;
                    digit_c[1] = {1'b0, b_q[7:4]};
                    digit_c[0] = {1'b0, b_q[3:0]};
                end
                default: begin
                    digit_c[3] = DIG_O;
                    digit_c[0] = {3'b000, op_q};
                end
            endcase
        end
        cur_digit_c = digit_c[scan_idx];
    end

    // Glyph decoder, active-low gfedcba
    always_comb begin
        glyph_c = 7'b1111111;
        case (cur_digit_c)
            5'h00:   glyph_c = 7'b1000000;
            5'h01:   glyph_c = 7'b1111001;
            5'h02:   glyph_c = 7'b0100100;
            5'h03:   glyph_c = 7'b0110000;
            5'h04:   glyph_c = 7'b0011001;
            5'h05:   glyph_c = 7'b0010010;
            5'h06:   glyph_c = 7'b0000010;
            5'h07:   glyph_c = 7'b1111000;
            5'h08:   glyph_c = 7'b0000000;
            5'h09:   glyph_c = 7'b0010000;
            5'h0A:   glyph_c = 7'b0001000;
            5'h0B:   glyph_c = 7'b0000011;
            5'h0C:   glyph_c = 7'b1000110;
            5'h0D:   glyph_c = 7'b0100001;
            5'h0E:   glyph_c = 7'b0000110;
            5'h0F:   glyph_c = 7'b0001110;
            DIG_O:   glyph_c = 7'b0100011;
            default: glyph_c = 7'b1111111;
        endcase
    end

    // Registered anode and cathode drives; dark while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 8'hFF;
        end else begin
            an  <= ~(4'b0001 << scan_idx);
            seg <= {1'b1, glyph_c};
        end
    end

endmodule

// File: tb/tb_simple_calculator.sv
// Self-checking bench for simple_calculator: directed scenarios followed by
// random button combinations, compared against an arithmetic model of the
// calculator and its display contents.
module tb_simple_calculator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btnU, btnD, btnL, btnR, btnS, sw;
    logic [3:0] an;
    logic [7:0] seg;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_a, m_b, m_op, m_field, m_res;
    bit m_show;

    always #5 clk = ~clk;

    simple_calculator #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btnU (btnU),
        .btnD (btnD),
        .btnL (btnL),
        .btnR (btnR),
        .btnS (btnS),
        .sw   (sw),
        .an   (an),
        .seg  (seg)
    );

    // Character code: 0..15 hex, 16 blank, 17 lowercase o
    function automatic logic [6:0] glyph(input int code);
        case (code)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            17: return 7'b0100011;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int exp_code(input int pos);
        if (m_show) return (m_res >> (4 * pos)) & 15;
        case (m_field)
            0: begin
                if (pos == 3) return 10;
                if (pos == 1) return (m_a >> 4) & 15;
                if (pos == 0) return m_a & 15;
                return 16;
            end
            1: begin
                if (pos == 3) return 11;
                if (pos == 1) return (m_b >> 4) & 15;
                if (pos == 0) return m_b & 15;
                return 16;
            end
            default: begin
                if (pos == 3) return 17;
                if (pos == 0) return m_op;
                return 16;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_field = 0; m_res = 0; m_show = 0;
    endtask

    // mask bits: [4]=S [3]=R [2]=L [1]=U [0]=D
    task automatic model_press(input logic [4:0] mask, input bit sw_v);
        int step;
        step = sw_v ? 16 : 1;
        if (mask[4]) begin
            case (m_op)
                0: m_res = (m_a + m_b) & 16'hFFFF;
                1: m_res = (m_a - m_b) & 16'hFFFF;
                2: m_res = (m_a * m_b) & 16'hFFFF;
                default: m_res = m_a & m_b;
            endcase
            m_show = 1;
        end else if (mask[3]) begin
            m_field = (m_field + 1) % 3; m_show = 0;
        end else if (mask[2]) begin
            m_field = (m_field + 2) % 3; m_show = 0;
        end else if (mask[1]) begin
            if (m_field == 0) m_a = (m_a + step) % 256;
            else if (m_field == 1) m_b = (m_b + step) % 256;
            else m_op = (m_op + 1) % 4;
            m_show = 0;
        end else if (mask[0]) begin
            if (m_field == 0) m_a = (m_a - step + 256) % 256;
            else if (m_field == 1) m_b = (m_b - step + 256) % 256;
            else m_op = (m_op + 3) % 4;
            m_show = 0;
        end
    endtask

    task automatic drive_btns(input logic [4:0] mask);
        {btnS, btnR, btnL, btnU, btnD} = mask;
    endtask

    task automatic press_hold(input logic [4:0] mask, input int hold);
        drive_btns(mask);
        repeat (hold) @(negedge clk);
        drive_btns(5'b0);
        repeat (20) @(negedge clk);
        model_press(mask, sw);
    endtask

    task automatic press(input logic [4:0] mask);
        press_hold(mask, 20);
    endtask

    // Watch one full scan and compare every lit digit with the expected codes
    task automatic check_codes(input int c3, input int c2, input int c1, input int c0,
                               input string tag);
        int       codes[4];
        int       idx;
        bit [3:0] seen;
        codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
        seen = '0;
        repeat (16) begin
            @(negedge clk);
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            checks++;
            assert (idx >= 0) else begin
                errors++;
                $error("FAIL %s anode observed=%b required=one-low", tag, an);
            end
            if (idx >= 0) begin
                seen[idx] = 1'b1;
                checks++;
                assert (seg === {1'b1, glyph(codes[idx])}) else begin
                    errors++;
                    $error("FAIL %s digit%0d seg observed=%b required=%b",
                           tag, idx, seg, {1'b1, glyph(codes[idx])});
                end
            end
        end
        checks++;
        assert (seen === 4'hF) else begin
            errors++;
            $error("FAIL %s scan coverage observed=%b required=1111", tag, seen);
        end
    endtask

    task automatic check_model(input string tag);
        check_codes(exp_code(3), exp_code(2), exp_code(1), exp_code(0), tag);
    endtask

    task automatic check_hex(input logic [15:0] v, input string tag);
        check_codes(int'(v[15:12]), int'(v[11:8]), int'(v[7:4]), int'(v[3:0]), tag);
    endtask

    task automatic set_field(input int f);
        while (m_field != f) press(5'b01000);
    endtask

    task automatic set_operand(input int f, input int v);
        int cur, diff;
        set_field(f);
        cur = (f == 0) ? m_a : m_b;
        while (cur != v) begin
            diff = (v - cur + 256) % 256;
            sw = (diff >= 16);
            press(5'b00010);
            cur = (f == 0) ? m_a : m_b;
        end
        sw = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_op(input int v);
        set_field(2);
        while (m_op != v) press(5'b00010);
    endtask

    initial begin
        int t;
        int k;
        int idx;
        logic [4:0] mask;

        rst_n = 1'b0;
        sw    = 1'b0;
        drive_btns(5'b0);
        model_reset();

        // Reset: display dark
        repeat (3) @(negedge clk);
        checks++;
        assert (an === 4'b1111) else begin
            errors++; $error("FAIL reset_an observed=%b required=1111", an);
        end
        checks++;
        assert (seg === 8'hFF) else begin
            errors++; $error("FAIL reset_seg observed=%h required=ff", seg);
        end

        // Release: first lit digit is d0, then strict 4-cycle rotation
        rst_n = 1'b1;
        t = 0;
        while (an === 4'b1111 && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        assert (an === 4'b1110) else begin
            errors++; $error("FAIL first_digit observed=%b required=1110", an);
        end
        for (k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            idx = (k / 4) % 4;
            checks++;
            assert (an === ~(4'b0001 << idx)) else begin
                errors++;
                $error("FAIL scan_order k=%0d an observed=%b required=%b",
                       k, an, ~(4'b0001 << idx));
            end
            checks++;
            assert (seg === {1'b1, glyph(exp_code(idx))}) else begin
                errors++;
                $error("FAIL reset_glyph k=%0d seg observed=%b required=%b",
                       k, seg, {1'b1, glyph(exp_code(idx))});
            end
        end

        // Field B, increment, compute 0+1
        press(5'b01000);
        check_model("field_b");
        press(5'b00010);
        check_model("b_inc");
        press(5'b10000);
        check_hex(16'h0001, "add_0_1");

        // Short glitch is ignored; long hold gives exactly one step
        drive_btns(5'b00010);
        repeat (2) @(negedge clk);
        drive_btns(5'b0);
        repeat (20) @(negedge clk);
        check_hex(16'h0001, "glitch_ignored");
        press_hold(5'b00010, 1000);
        check_model("long_hold");

        // Wrap cases
        press(5'b00100);
        check_model("back_to_a");
        press(5'b00001);
        check_model("a_wrap_ff");
        press(5'b00010);
        sw = 1'b1;
        repeat (3) @(negedge clk);
        press(5'b00010);
        check_model("a_step16");
        sw = 1'b0;
        press(5'b00100);
        check_model("l_wrap_to_op");
        press(5'b00001);
        check_model("op_wrap_down");
        press(5'b00010);
        check_model("op_wrap_up");

        // Arithmetic
        set_operand(0, 8'h03);
        set_operand(1, 8'h05);
        set_op(1);
        press(5'b10000);
        check_hex(16'hFFFE, "sub_3_5");
        set_operand(0, 8'hFF);
        set_operand(1, 8'hFF);
        set_op(2);
        press(5'b10000);
        check_hex(16'hFE01, "mul_ff_ff");
        set_op(0);
        press(5'b10000);
        check_hex(16'h01FE, "add_ff_ff");
        set_op(3);
        press(5'b10000);
        check_hex(16'h00FF, "and_ff_ff");
        press(5'b00010);
        check_model("result_cleared");

        // Reset mid-operation
        set_operand(0, 8'h12);
        set_op(2);
        press(5'b10000);
        check_model("pre_reset_mul");
        rst_n = 1'b0;
        #1;
        checks++;
        assert (an === 4'b1111) else begin
            errors++; $error("FAIL midreset_an observed=%b required=1111", an);
        end
        checks++;
        assert (seg === 8'hFF) else begin
            errors++; $error("FAIL midreset_seg observed=%h required=ff", seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_codes(10, 16, 0, 0, "after_reset");
        press(5'b10010);
        check_hex(16'h0000, "s_beats_u");
        press(5'b01000);
        check_model("b_after_reset");
        press(5'b00100);
        check_model("a_after_reset");

        // Random button combinations and step sizes
        for (int i = 0; i < 40; i++) begin
            sw = 1'($urandom_range(0, 1));
            repeat (3) @(negedge clk);
            if ($urandom_range(0, 1) == 0)
                mask = 5'b00001 << $urandom_range(0, 4);
            else
                mask = 5'($urandom_range(1, 31));
            press(mask);
            check_model("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simple_calculator.md
Name: simple_calculator

Overview:
- Push-button integer calculator for a 100 MHz FPGA board with a 4-digit multiplexed 7-segment display.
- The user edits two 8-bit unsigned operands and an operator with the five buttons, then presses the centre button to compute a 16-bit result.
- Top-level board block: raw buttons in; anode and segment drives out.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (5 ms).
- REFRESH_CYCLES, 100000, cycles each digit stays lit during display scanning (1 ms).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btnU  in  1  increment the selected field; raw, active-high.
- btnD  in  1  decrement the selected field.
- btnL  in  1  select the previous field.
- btnR  in  1  select the next field.
- btnS  in  1  compute and show the result.
- sw  in  1  step size: 0 = ±1, 1 = ±16 (operands only).
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  8  cathodes, active-low; seg[0]=a … seg[6]=g, seg[7]=dp.

Behaviour:
- Reset is one clock, asynchronous and active-low:
  - While rst_n=0: an=4'b1111, seg=8'hFF.
  - Registers clear: A=0, B=0, op=0 (ADD), field=A, result=0, show_result=0, debouncers=0, scan index=0.
- Button conditioning, per button:
  - Two-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - The debounced rising edge gives a one-cycle pulse. No auto-repeat; release does nothing.
  - Simultaneous pulses: priority btnS > btnR > btnL > btnU > btnD. Only the winner acts; the others are dropped.
- Field selection: ring A → B → OP → A.
  - btnR advances; btnL goes back; both wrap.
  - Both set show_result=0.
- Edit, with step = sw ? 16 : 1:
  - btnU on A/B: add step, mod 256.
  - btnD on A/B: subtract step, mod 256 (0 − 1 = 8'hFF).
  - On OP: btnU/btnD increment/decrement the 2-bit op mod 4; sw is ignored.
  - Edits set show_result=0.
- Compute (btnS): register the 16-bit result the cycle after the pulse, and set show_result=1.
  - op 0 ADD: A+B, zero-extended.
  - op 1 SUB: A−B, mod 2^16.
  - op 2 MUL: A×B.
  - op 3 AND: A&B, zero-extended.
  - A, B, op and field are unchanged.
- Display contents, digits listed d3..d0:
  - show_result=1: four hex digits of the result.
  - Field A: 'A', blank, A[7:4], A[3:0].
  - Field B: 'b', blank, B[7:4], B[3:0].
  - Field OP: 'o', blank, blank, op code 0–3.
- Display scanning:
  - Scan index advances every REFRESH_CYCLES cycles: 0,1,2,3,0…
  - Exactly one anode is low: an = ~(1<<index). seg shows that digit's glyph.
  - First lit digit after reset is d0 (an=4'b1110).
- Glyphs, active-low gfedcba:
  - Hex 0–F standard, lowercase b and d.
  - '0'=1000000, '1'=1111001, '8'=0000000, 'A'=0001000, 'b'=0000011, 'E'=0000110, 'F'=0001110, 'o'=0100011, blank=1111111.
  - dp is always 1 (off).
- Display updates are combinational from registered state and settle within the same refresh slot.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REFRESH_CYCLES=4, 10 ns clock):
- Reset, then run 32 cycles:
  - an cycles 1110, 1101, 1011, 0111.
  - Glyphs are '0', '0', blank, 'A' (seg[6:0] = 1000000, 1000000, 1111111, 0001000).
  - seg[7]=1 throughout.
- Press btnR (hold 20 cycles, release), then btnU, then btnS:
  - d3 shows 'b', then B=8'h01.
  - After btnS, the result 0+1 shows "0001", with d0 = 1111001.
- btnU pulse of 2 cycles (shorter than the debounce) → no change.
  - Holding btnU for 1000 cycles → exactly one increment.
- Wrap cases:
  - Field A, A=0, btnD → "FF".
  - sw=1, btnU from A=0 → "10".
  - Field OP at op=3, btnU → op=0.
  - btnL from field A → field OP ('o').
- Arithmetic:
  - A=3, B=5, SUB → FFFE.
  - A=FF, B=FF, MUL → FE01; ADD → 01FE; AND → 00FF.
  - Any later btnU clears the result view.
- Reset mid-operation:
  - Set A=12, op=MUL, show_result=1, then pulse rst_n low for 1 cycle.
  - Immediately an=1111, seg=FF; after release, display "A 00" and state fully cleared.
  - btnU and btnS pressed in the same cycle → only the compute occurs; operands unchanged.
